// File: rtl/trim_pkg.sv
// trim_pkg: shared definitions for the BGR trim receive path.
//   trim_state_t      receiver state encoding
//   TRIM_W            trim word width / bits per frame
//   TRIM_IDLE_TIMEOUT default CLK50 cycles of ENCLK low that close a frame
//   TRIM_TO_W         default idle-timeout counter width
package trim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } trim_state_t;

    localparam int TRIM_W            = 12;
    localparam int TRIM_IDLE_TIMEOUT = 50000000;
    localparam int TRIM_TO_W         = 26;

endpackage

// File: rtl/trim_sync.sv
// trim_sync: brings the generator's ENCLK/DOUT into the CLK50 domain.
//   CLK50, RST  system clock, synchronous active-high reset
//   enclk, dout raw serial clock and data from the trim generator
//   enclk_lvl   conditioned ENCLK level
//   dout_smp    DOUT delayed to line up with fall
//   fall        one-cycle falling-edge indication on the conditioned ENCLK
// Build option: TRIM_RX_GLITCH_FILTER_EN adds a 3-sample glitch filter on
// ENCLK (edge latency 5 instead of 3) and delays DOUT by the same 2 cycles.
module trim_sync (
    input  logic CLK50,
    input  logic RST,
    input  logic enclk,
    input  logic dout,
    output logic enclk_lvl,
    output logic dout_smp,
    output logic fall
);

    // bit 0 is the first synchronizer stage, bit 1 the usable output
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;

    always_ff @(posedge CLK50) begin
        if (RST) begin
            clk_sync <= 2'b00;
            dat_sync <= 2'b00;
        end else begin
            clk_sync <= {clk_sync[0], enclk};
            dat_sync <= {dat_sync[0], dout};
        end
    end

`ifdef TRIM_RX_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic [1:0] dat_dly;
    logic       filt_q;
    logic       filt;

    // Filtered level follows the synchronized level only once the current
    // sample and the two before it agree, so 1-2 cycle pulses never pass.
    always_comb begin
        filt = filt_q;
        if ((clk_sync[1] == hist[0]) && (hist[0] == hist[1]))
            filt = clk_sync[1];
    end

    always_ff @(posedge CLK50) begin
        if (RST) begin
            hist    <= 2'b00;
            dat_dly <= 2'b00;
            filt_q  <= 1'b0;
        end else begin
            hist    <= {hist[0], clk_sync[1]};
            dat_dly <= {dat_dly[0], dat_sync[1]};
            filt_q  <= filt;
        end
    end

    assign enclk_lvl = filt;
    assign dout_smp  = dat_dly[1];
    assign fall      = filt_q & ~filt;
`else
    logic enclk_prev;

    always_ff @(posedge CLK50) begin
        if (RST)
            enclk_prev <= 1'b0;
        else
            enclk_prev <= clk_sync[1];
    end

    assign enclk_lvl = clk_sync[1];
    assign dout_smp  = dat_sync[1];
    assign fall      = enclk_prev & ~clk_sync[1];
`endif

endmodule

// File: rtl/trim_rx.sv
// trim_rx: deserializes LSB-first trim frames from the BGR trim generator.
//   CLK50       50 MHz system clock
//   RST         synchronous active-high reset
//   ENCLK, DOUT serial clock / data from the generator (asynchronous)
//   TRIM_OUT    last good received trim code
//   TRIM_VALID  one-cycle pulse, coincident with TRIM_OUT updating
//   FRAME_ERR   one-cycle pulse when a frame closes with a wrong bit count
//   BUSY        high while a frame is being received
//   FRAME_CNT   good-frame count, wraps 255 -> 0
// Build option: TRIM_RX_GLITCH_FILTER_EN (see trim_sync).
//
// state | meaning
// IDLE  | waiting for the first ENCLK falling edge
// RECV  | shifting bits, watching for ENCLK idle-low timeout
// DONE  | single cycle: publish word or flag error, then clear
module trim_rx
    import trim_pkg::*;
#(
    parameter int DATA_W       = TRIM_W,
    parameter int IDLE_TIMEOUT = TRIM_IDLE_TIMEOUT,
    parameter int TO_W         = TRIM_TO_W
) (
    input  logic              CLK50,
    input  logic              RST,
    input  logic              ENCLK,
    input  logic              DOUT,
    output logic [DATA_W-1:0] TRIM_OUT,
    output logic              TRIM_VALID,
    output logic              FRAME_ERR,
    output logic              BUSY,
    output logic [7:0]        FRAME_CNT
);

    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(DATA_W + 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(IDLE_TIMEOUT);

    logic enclk_lvl;
    logic dout_smp;
    logic fall;

    trim_sync u_sync (
        .CLK50     (CLK50),
        .RST       (RST),
        .enclk     (ENCLK),
        .dout      (DOUT),
        .enclk_lvl (enclk_lvl),
        .dout_smp  (dout_smp),
        .fall      (fall)
    );

    trim_state_t       state_q, state_d;
    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [DATA_W-1:0] trim_q;
    logic              valid_q;
    logic              err_q;
    logic [7:0]        frame_cnt_q;
    logic              busy_c;
    logic              good_c;
    logic              bad_c;

    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        good_c  = 1'b0;
        bad_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall)
                    state_d = RECV;
            end
            RECV: begin
                busy_c = 1'b1;
                if (to_cnt_q == TO_LIMIT)
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (bit_cnt_q == CNT_FULL)
                    good_c = 1'b1;
                else
                    bad_c = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK50) begin
        if (RST) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            trim_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            valid_q <= good_c;
            err_q   <= bad_c;
            if (good_c) begin
                trim_q      <= shreg_q;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        shreg_q   <= {dout_smp, shreg_q[DATA_W-1:1]};
                        bit_cnt_q <= CNT_W'(1);
                        to_cnt_q  <= '0;
                    end
                end
                RECV: begin
                    if (fall) begin
                        shreg_q <= {dout_smp, shreg_q[DATA_W-1:1]};
                        // saturating one past full marks an overlong frame
                        if (bit_cnt_q != CNT_OVF)
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    if (fall || enclk_lvl)
                        to_cnt_q <= '0;
                    else
                        to_cnt_q <= to_cnt_q + 1'b1;
                end
                default: begin
                    // DONE: any edge arriving now is deliberately dropped
                    shreg_q   <= '0;
                    bit_cnt_q <= '0;
                    to_cnt_q  <= '0;
                end
            endcase
        end
    end

    assign TRIM_OUT   = trim_q;
    assign TRIM_VALID = valid_q;
    assign FRAME_ERR  = err_q;
    assign BUSY       = busy_c;
    assign FRAME_CNT  = frame_cnt_q;

endmodule

// File: doc/trim_rx.md
Name: trim_rx

Overview:
- Receive-side deserializer that sits directly downstream of the BGR trim generator.
- Oversamples the generator's gated serial clock ENCLK and data DOUT in the CLK50 domain, then reassembles each LSB-first 12-bit frame.
- Presents the recovered code as a parallel trim word with a one-cycle valid strobe and a frame-error strobe.
- Feeds the trim register and bench checker, which confirm the code the generator shifted out.

Parameters:
- DATA_W, 12, trim word width and the expected bit count per frame.
- IDLE_TIMEOUT, 50000000, CLK50 cycles with ENCLK held low that end a frame. Must exceed the ENCLK low half-period.
- TO_W, 26, width of the idle-timeout counter. Must satisfy 2^TO_W > IDLE_TIMEOUT.

Ports:
- CLK50  in  1  system clock, 50 MHz
- RST  in  1  reset; one clock, reset is synchronous and active-high
- ENCLK  in  1  serial clock from the trim generator, asynchronous to CLK50
- DOUT  in  1  serial data from the trim generator; changes after ENCLK rises
- TRIM_OUT  out  DATA_W  last good received trim code
- TRIM_VALID  out  1  one-cycle pulse when TRIM_OUT updates
- FRAME_ERR  out  1  one-cycle pulse when a frame ends with bit count != DATA_W
- BUSY  out  1  high while a frame is being received
- FRAME_CNT  out  8  count of good frames; wraps 255 -> 0

Behaviour:
- Reset (sync, RST high at a CLK50 edge):
  - TRIM_OUT=0, TRIM_VALID=0, FRAME_ERR=0, BUSY=0, FRAME_CNT=0.
  - Synchronizer and edge flops cleared; shift register, bit counter and timeout counter cleared.
  - State goes to IDLE.
- Input conditioning:
  - ENCLK and DOUT each pass through a 2-flop synchronizer; ENCLK then has a previous-value flop.
  - Falling edge = prev=1 & sync=0. DOUT is sampled at the falling edge, the mid-bit point.
  - Latency from a pin edge to the sample: 3 CLK50 cycles.
- Shifting:
  - On each sampled bit: shreg <= {dout_s, shreg[DATA_W-1:1]} (LSB first); bit_cnt increments.
  - bit_cnt saturates at DATA_W+1, which means overflow.
- State machine:
  - IDLE: BUSY=0. A falling edge captures the first bit, sets bit_cnt=1 and moves to RECV.
  - RECV: BUSY=1.
    - The timeout counter clears whenever the synchronized ENCLK is high or an edge occurs, and otherwise increments.
    - When it reaches IDLE_TIMEOUT, go to DONE.
  - DONE (exactly 1 cycle):
    - bit_cnt==DATA_W: TRIM_OUT<=shreg, TRIM_VALID=1, FRAME_CNT+1.
    - Otherwise: FRAME_ERR=1 and TRIM_OUT is held.
    - Clear the counters and return to IDLE.
- Boundaries:
  - A falling edge in the DONE cycle is dropped.
  - TRIM_VALID and FRAME_ERR are never high in the same cycle.
  - An overflowed frame (>12 bits) raises FRAME_ERR.
  - RST mid-frame discards the partial frame; no strobe is issued.
  - ENCLK stuck high keeps the block in RECV indefinitely; no timeout, no strobe.

Optional Feature:
- Macro: TRIM_RX_GLITCH_FILTER_EN
- Defined:
  - The synchronized ENCLK passes a 3-sample filter; the filtered level changes only after 3 consecutive equal samples.
  - Edge latency becomes 5 cycles.
  - A pulse of 1-2 cycles on ENCLK produces no edge.
  - DOUT is delayed 2 extra cycles to stay aligned with ENCLK.
- Undefined: no filter; 3-cycle latency; every synchronized transition counts as an edge.

Decomposition:
- Package trim_pkg holds:
  - the state encoding (IDLE=2'd0, RECV=2'd1, DONE=2'd2);
  - TRIM_W=12;
  - the default IDLE_TIMEOUT.
- Sub-module trim_sync:
  - 2-flop synchronizer, optional glitch filter and edge detect;
  - instantiated once for ENCLK, with DOUT riding the same delay line.

Test Plan:
- Set IDLE_TIMEOUT=16, ENCLK half-period 8 cycles.
- Good frame: send 12'hA5C LSB-first, then ENCLK low for 20 cycles -> TRIM_OUT=12'hA5C, TRIM_VALID 1 cycle, FRAME_CNT=1, FRAME_ERR=0.
- Short frame: 7 bits then idle -> FRAME_ERR 1 cycle, TRIM_OUT holds 12'hA5C, FRAME_CNT unchanged.
- Long frame: 13 bits then idle -> FRAME_ERR pulse, no TRIM_VALID.
- Reset mid-frame: RST after 5 bits, then a clean 12'h001 frame -> only TRIM_OUT=12'h001 with one TRIM_VALID; all outputs 0 while RST is high.
- Back-to-back: 256 good frames of an incrementing code -> FRAME_CNT wraps to 0 and the last TRIM_OUT equals the last code sent.
- Glitch (TRIM_RX_GLITCH_FILTER_EN defined): a 1-cycle ENCLK low blip inside a high phase -> no extra bit and the frame decodes correctly. With the macro undefined -> FRAME_ERR.
